uart_tx_hs: RTL and testbench



---
 rtl/uart_pkg.sv | 33 +++
 rtl/uart_baud_cnt.sv | 32 +++
 rtl/uart_tx_hs.sv | 128 ++++++++++++
 tb/tb_uart_tx_hs.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART types, constants and bit-order helpers.
// Used by uart_tx_hs and uart_baud_cnt.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;
  localparam int UART_DEFAULT_BAUD_CYCLE = 868;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_t;

  function automatic logic headBit(
    input logic [UART_DATA_BITS-1:0] d,
    input logic lsbFirst
  );
    return lsbFirst ? d[0] : d[UART_DATA_BITS-1];
  endfunction

  // Rotate rather than shift so the byte is whole again after 8 bits.
  function automatic logic [UART_DATA_BITS-1:0] rotByte(
    input logic [UART_DATA_BITS-1:0] d,
    input logic lsbFirst
  );
    if (lsbFirst)
      return {d[0], d[UART_DATA_BITS-1:1]};
    return {d[UART_DATA_BITS-2:0], d[UART_DATA_BITS-1]};
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: bitDone marks the last cycle of each period.
// Shared between the UART transmitter and receiver.
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int BAUD_CYCLE = UART_DEFAULT_BAUD_CYCLE
) (
  input  logic clk,
  input  logic rstB,
  input  logic clr,
  input  logic en,
  output logic bitDone
);

  localparam int CW = (BAUD_CYCLE > 2) ? $clog2(BAUD_CYCLE) : 1;
  localparam logic [CW-1:0] LAST = CW'(BAUD_CYCLE - 1);

  logic [CW-1:0] cnt;

  assign bitDone = en && !clr && (cnt == LAST);

  always_ff @(posedge clk or negedge rstB) begin
    if (!rstB) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= bitDone ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_hs.sv
// UART transmitter with valid/ready byte input and registered tx.
// Define UART_TX_PARITY_EN to insert a parity bit after the data.
module uart_tx_hs
  import uart_pkg::*;
#(
  parameter int   BAUD_CYCLE = UART_DEFAULT_BAUD_CYCLE,
  parameter logic LSB_FIRST  = 1'b1,
  parameter int   STOP_BITS  = 1,
  parameter logic PARITY_ODD = 1'b0
) (
  input  logic                      clk,
  input  logic                      rstB,
  input  logic                      txValid,
  input  logic [UART_DATA_BITS-1:0] txData,
  output logic                      txReady,
  output logic                      tx,
  output logic                      busy
);

  localparam int BW = $clog2(UART_DATA_BITS);
  localparam logic [BW-1:0] LAST_DATA = BW'(UART_DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

  if (STOP_BITS != 1 && STOP_BITS != 2) begin : gBadStop
    $error("uart_tx_hs: STOP_BITS must be 1 or 2");
  end
  if (BAUD_CYCLE < 2) begin : gBadBaud
    $error("uart_tx_hs: BAUD_CYCLE must be >= 2");
  end
  if (PARITY_ODD !== 1'b0 && PARITY_ODD !== 1'b1) begin : gBadPar
    $error("uart_tx_hs: PARITY_ODD must be 0 or 1");
  end

  uart_tx_state_t state;
  logic [BW-1:0] bitCnt;
  logic [UART_DATA_BITS-1:0] shReg;
  logic bitDone;
  logic [UART_DATA_BITS-1:0] shNext;

  assign shNext = rotByte(shReg, LSB_FIRST);

  uart_baud_cnt #(
    .BAUD_CYCLE(BAUD_CYCLE)
  ) uBaud (
    .clk    (clk),
    .rstB   (rstB),
    .clr    (state == IDLE),
    .en     (busy),
    .bitDone(bitDone)
  );

  always_ff @(posedge clk or negedge rstB) begin
    if (!rstB) begin
      state   <= IDLE;
      bitCnt  <= '0;
      shReg   <= '0;
      tx      <= 1'b1;
      txReady <= 1'b1;
      busy    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (txValid && txReady) begin
            shReg   <= txData;
            bitCnt  <= '0;
            state   <= START;
            tx      <= 1'b0;
            txReady <= 1'b0;
            busy    <= 1'b1;
          end
        end
        START: begin
          if (bitDone) begin
            state <= DATA;
            tx    <= headBit(shReg, LSB_FIRST);
          end
        end
        DATA: begin
          if (bitDone) begin
            shReg <= shNext;
            if (bitCnt == LAST_DATA) begin
              bitCnt <= '0;
`ifdef UART_TX_PARITY_EN
              state <= PARITY;
              tx    <= (^shReg) ^ PARITY_ODD;
`else
              state <= STOP;
              tx    <= 1'b1;
`endif
            end else begin
              bitCnt <= bitCnt + 1'b1;
              tx     <= headBit(shNext, LSB_FIRST);
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bitDone) begin
            state  <= STOP;
            bitCnt <= '0;
            tx     <= 1'b1;
          end
        end
`endif
        STOP: begin
          if (bitDone) begin
            if (bitCnt == LAST_STOP) begin
              state   <= IDLE;
              bitCnt  <= '0;
              txReady <= 1'b1;
              busy    <= 1'b0;
            end else begin
              bitCnt <= bitCnt + 1'b1;
            end
          end
        end
        default: begin
          state   <= IDLE;
          bitCnt  <= '0;
          tx      <= 1'b1;
          txReady <= 1'b1;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_hs.sv
// Randomized bench for uart_tx_hs: two configurations checked
// cycle by cycle against a frame-timing reference model.
module tb_uart_tx_hs;

`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic clk = 1'b0;
  logic rstB = 1'b0;
  always #5 clk = ~clk;

  logic       txValid [2];
  logic [7:0] txData  [2];
  logic       txReady [2];
  logic       tx      [2];
  logic       busy    [2];

  int checks = 0;
  int errors = 0;
  int mode = 0;
  logic [7:0] dirList [7] =
    '{8'h5C, 8'hCC, 8'h00, 8'hFF, 8'hA1, 8'h07, 8'h3E};

  task automatic check(
    input string tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  // Line level k cycles after the accept edge.
  function automatic logic expBit(
    input logic [7:0] b,
    input int k,
    input int bc,
    input bit lsb,
    input bit odd
  );
    int idx;
    idx = k / bc;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return lsb ? b[idx-1] : b[8-idx];
    if (P == 1 && idx == 9) return (^b) ^ odd;
    return 1'b1;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : gen
    localparam int BC  = (g == 0) ? 6 : 5;
    localparam bit LSB = (g == 0);
    localparam int SB  = (g == 0) ? 1 : 2;
    localparam bit ODD = (g != 0);
    localparam int FL  = (9 + P + SB) * BC;

    logic mBusy = 1'b0;
    int mK = 0;
    logic [7:0] mByte = 8'h00;
    int accCnt = 0;

    uart_tx_hs #(
      .BAUD_CYCLE(BC),
      .LSB_FIRST (LSB),
      .STOP_BITS (SB),
      .PARITY_ODD(ODD)
    ) dut (
      .clk    (clk),
      .rstB   (rstB),
      .txValid(txValid[g]),
      .txData (txData[g]),
      .txReady(txReady[g]),
      .tx     (tx[g]),
      .busy   (busy[g])
    );

    always @(posedge clk or negedge rstB) begin
      if (!rstB) begin
        mBusy = 1'b0;
        mK = 0;
      end else if (mBusy) begin
        mK++;
        if (mK == FL) mBusy = 1'b0;
      end else if (txValid[g]) begin
        mBusy = 1'b1;
        mK = 0;
        mByte = txData[g];
        accCnt++;
      end
    end

    always @(negedge clk) begin
      check($sformatf("busy%0d", g), busy[g], mBusy);
      check($sformatf("ready%0d", g), txReady[g], !mBusy);
      check($sformatf("tx%0d", g), tx[g],
            mBusy ? expBit(mByte, mK, BC, LSB, ODD) : 1'b1);
      #1;
      case (mode)
        1: begin
          txValid[g] = 1'b1;
          txData[g] = 8'($urandom);
        end
        2: begin
          txValid[g] = ($urandom_range(0, 19) == 0);
          txData[g] = 8'($urandom);
        end
        3: begin
          txValid[g] = 1'b1;
          txData[g] = dirList[accCnt % 7];
        end
        default: begin
          txValid[g] = ($urandom_range(0, 3) != 0);
          txData[g] = 8'($urandom);
        end
      endcase
    end
  end

  initial begin
    bit found;
    for (int i = 0; i < 2; i++) begin
      txValid[i] = 1'b0;
      txData[i] = 8'h00;
    end
    mode = 0;
    rstB = 1'b0;
    repeat (3) @(negedge clk);
    #3 rstB = 1'b1;

    mode = 3;
    repeat (600) @(negedge clk);
    mode = 1;
    repeat (2000) @(negedge clk);
    mode = 0;
    repeat (2000) @(negedge clk);
    mode = 2;
    repeat (2000) @(negedge clk);

    mode = 1;
    found = 1'b0;
    for (int i = 0; i < 1000 && !found; i++) begin
      @(negedge clk);
      if (gen[0].mBusy && (gen[0].mK / 6) == 5) found = 1'b1;
    end
    check("wait_bit4", found, 1);

    @(posedge clk);
    #2 rstB = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("arst_tx%0d", i), tx[i], 1);
      check($sformatf("arst_busy%0d", i), busy[i], 0);
      check($sformatf("arst_ready%0d", i), txReady[i], 1);
    end
    @(negedge clk);
    #3 rstB = 1'b1;

    mode = 3;
    repeat (600) @(negedge clk);
    mode = 0;
    repeat (500) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
